// File: rtl/moore_seq_gen_1010_pkg.sv
// Shared definitions for the 1010 pattern transmitter and its matching detectors.
// Holds the state encoding and the reference pattern both ends agree on.
package moore_seq_gen_1010_pkg;

   localparam int unsigned SEQ_W = 4;
   localparam logic [SEQ_W-1:0] SEQ_1010 = 4'b1010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage : moore_seq_gen_1010_pkg

// File: rtl/moore_seq_gen_1010.sv
// Moore serial pattern transmitter: sends PATTERN MSB-first, rep times, paced by bit_en,
// with GAP_CYC idle bit periods between repetitions and a one-cycle done pulse at the end.
module moore_seq_gen_1010
   import moore_seq_gen_1010_pkg::*;
#(
   parameter int unsigned       PAT_W   = SEQ_W,
   parameter logic [PAT_W-1:0]  PATTERN = PAT_W'(SEQ_1010),
   parameter int unsigned       GAP_CYC = 1,
   parameter int unsigned       CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             bit_en,
   input  logic [CNT_W-1:0] rep,
   output logic             x_out,
   output logic             x_valid,
   output logic             busy,
   output logic             done
);

   localparam int unsigned IDX_W = $clog2(PAT_W);
   // A zero-width gap counter is not legal, so keep at least one bit when GAP_CYC=0.
   localparam int unsigned GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   rep_left_q, rep_left_d;
   logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
   logic               x_out_q, x_out_d;
   logic               x_valid_q, x_valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [IDX_W-1:0]   bit_sel;

   // State, counters and decoded outputs all register here.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         rep_left_q <= '0;
         gap_cnt_q  <= '0;
         x_out_q    <= 1'b0;
         x_valid_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         rep_left_q <= rep_left_d;
         gap_cnt_q  <= gap_cnt_d;
         x_out_q    <= x_out_d;
         x_valid_q  <= x_valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // Next-state and counter update.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      rep_left_d = rep_left_q;
      gap_cnt_d  = gap_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_SEND;
               idx_d      = '0;
               rep_left_d = (rep == '0) ? CNT_W'(1) : rep;
            end
         end

         ST_SEND: begin
            if (bit_en) begin
               if (idx_q != LAST_IDX) begin
                  idx_d = idx_q + IDX_W'(1);
               end else if (rep_left_q == CNT_W'(1)) begin
                  state_d = ST_DONE;
                  idx_d   = '0;
               end else begin
                  rep_left_d = rep_left_q - CNT_W'(1);
                  idx_d      = '0;
                  if (GAP_CYC > 0) begin
                     state_d   = ST_GAP;
                     gap_cnt_d = GAP_W'(GAP_CYC);
                  end
               end
            end
         end

         ST_GAP: begin
            if (bit_en) begin
               // Guarded at 1 so the counter never wraps.
               if (gap_cnt_q <= GAP_W'(1)) begin
                  state_d   = ST_SEND;
                  idx_d     = '0;
                  gap_cnt_d = '0;
               end else begin
                  gap_cnt_d = gap_cnt_q - GAP_W'(1);
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d    = ST_IDLE;
            idx_d      = '0;
            rep_left_d = '0;
            gap_cnt_d  = '0;
         end
      endcase
   end

   // Outputs are decoded from the upcoming state so the registered copy tracks state_q exactly.
   always_comb begin
      x_out_d   = 1'b0;
      x_valid_d = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      bit_sel   = LAST_IDX - idx_d;

      case (state_d)
         ST_SEND: begin
            x_out_d   = PATTERN[bit_sel];
            x_valid_d = 1'b1;
            busy_d    = 1'b1;
         end
         ST_GAP: begin
            busy_d = 1'b1;
         end
         ST_DONE: begin
            done_d = 1'b1;
         end
         default: begin
            x_out_d = 1'b0;
         end
      endcase
   end

   assign x_out   = x_out_q;
   assign x_valid = x_valid_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule : moore_seq_gen_1010

// File: doc/moore_seq_gen_1010.md
Name: moore_seq_gen_1010

Overview:
Moore-style serial pattern transmitter. It emits a fixed PAT_W-bit pattern (default 1010) MSB-first on a single-bit line, repeated a programmable number of times, with an idle gap between repetitions. It is the stimulus/transmit end for the team's 1010 non-overlapping sequence detectors and drives a detector's serial input directly. Bit timing is paced by an external bit-rate strobe.

Parameters:
PAT_W, 4, pattern length in bits (>=2)
PATTERN, 4'b1010, transmitted pattern; bit PAT_W-1 goes out first
GAP_CYC, 1, bit periods of idle (x_out=0, x_valid=0) between repetitions; 0 = back-to-back
CNT_W, 8, width of the repetition count

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
start  in  1  request to send; sampled only in IDLE
bit_en  in  1  bit-rate strobe; state advances only on clk edges where bit_en=1
rep  in  CNT_W  repetitions to send; latched on accepted start; 0 treated as 1
x_out  out  1  serial data; 0 when not sending
x_valid  out  1  high while x_out carries a pattern bit
busy  out  1  high in SEND and GAP
done  out  1  one-cycle pulse after the final bit period

Behaviour:
- Reset (rst=0, async): state=IDLE, bit index=0, rep counter=0, gap counter=0. Outputs x_out=0, x_valid=0, busy=0, done=0. Reset mid-transfer aborts immediately with no done pulse.
- Moore outputs: x_out, x_valid, busy and done are decoded from registered state, bit index and counters only. No input-to-output combinational path.
- States:
  - IDLE: start=1 at edge goes to SEND with idx=0 and rep_left=max(rep,1). Accepting start does not require bit_en.
  - SEND: x_out=PATTERN[PAT_W-1-idx], x_valid=1. On bit_en with idx<PAT_W-1, idx increments.
    - On bit_en with idx=PAT_W-1 and rep_left=1, go to DONE.
    - Otherwise decrement rep_left and set idx=0. Go to GAP with gap_cnt=GAP_CYC if GAP_CYC>0, else stay in SEND.
  - GAP: x_out=0, x_valid=0, busy=1. On bit_en, gap_cnt decrements. On bit_en with gap_cnt=1, go to SEND with idx=0.
  - DONE: done=1, busy=0, x_valid=0, exactly one clk cycle. Then IDLE unconditionally, ignoring bit_en.
  - Any illegal encoding goes to IDLE.
- Latency: start accepted at edge k puts the first bit on x_out in the cycle after edge k. Each bit is held until the edge where bit_en=1.
- Total bit periods = rep*PAT_W + (rep-1)*GAP_CYC, followed by one done cycle.
- Start handling:
  - start in SEND, GAP or DONE is ignored, not queued.
  - start held high continuously re-triggers from IDLE, so DONE-to-IDLE-to-SEND gives one idle cycle between bursts.
  - rep changes after acceptance have no effect.
- Counters: rep_left is CNT_W bits, gap counter is clog2(GAP_CYC+1) bits, idx is clog2(PAT_W) bits. No wrap-around is reachable: decrements are guarded at 1.

Decomposition:
- Shared package holds:
  - the state encoding localparams (IDLE=2'd0, SEND=2'd1, GAP=2'd2, DONE=2'd3);
  - the default pattern constant SEQ_1010=4'b1010, so transmitter and detectors agree on the pattern.
- No sub-module required. The bit_en strobe comes from the existing clock-divider/strobe logic outside this block.

Test Plan:
1. Reset, PATTERN=1010, GAP_CYC=1: rst=0 -> x_out=0, x_valid=0, busy=0, done=0. Release rst and hold start=0 for 5 cycles -> outputs unchanged.
2. bit_en=1 constant, rep=1, start pulse at edge 0 -> x_out=1,0,1,0 in cycles 1-4 with x_valid=1 and busy=1; done=1 only in cycle 5; IDLE in cycle 6.
3. rep=3, GAP_CYC=2, bit_en=1 -> pattern 1010 in cycles 1-4, 7-10 and 13-16; x_out=0 and x_valid=0 in cycles 5-6 and 11-12; done in cycle 17.
4. bit_en high every other cycle, rep=1 -> each of 1,0,1,0 held two cycles; done one cycle after the last held bit.
5. rep=0 -> identical to rep=1. start pulsed during SEND and again in the DONE cycle -> ignored: exactly one burst and one done pulse.
6. rst=0 asserted asynchronously in GAP of a rep=3 transfer -> outputs 0 immediately, no done pulse. A new start after release sends a full fresh burst from idx 0.
